// File: rtl/hazard_stall_controller_if.sv
// Pipeline-control bundle between the decode-side hazard sequencer and the core.
// slave = the sequencer itself, master = the pipeline that feeds it and consumes its controls.
interface hazard_stall_controller_if;
  logic [4:0] ID_RS1;
  logic [4:0] ID_RS2;
  logic       ID_USES_RS1;
  logic       ID_USES_RS2;
  logic [4:0] EX_DEST_REG;
  logic       EX_IS_LOAD;
  logic       EX_IS_MDU;
  logic       EX_BRANCH_TAKEN;
  logic       MDU_DONE;
  logic       PC_ENABLE;
  logic       IF_ID_ENABLE;
  logic       IF_ID_FLUSH;
  logic       ID_EX_ENABLE;
  logic       ID_EX_FLUSH;
  logic       EX_MEM_FLUSH;
  logic       MDU_START;
  logic       MDU_TIMEOUT_ERR;

  modport master (
    output ID_RS1, ID_RS2, ID_USES_RS1, ID_USES_RS2,
    output EX_DEST_REG, EX_IS_LOAD, EX_IS_MDU, EX_BRANCH_TAKEN, MDU_DONE,
    input  PC_ENABLE, IF_ID_ENABLE, IF_ID_FLUSH, ID_EX_ENABLE, ID_EX_FLUSH,
    input  EX_MEM_FLUSH, MDU_START, MDU_TIMEOUT_ERR
  );

  modport slave (
    input  ID_RS1, ID_RS2, ID_USES_RS1, ID_USES_RS2,
    input  EX_DEST_REG, EX_IS_LOAD, EX_IS_MDU, EX_BRANCH_TAKEN, MDU_DONE,
    output PC_ENABLE, IF_ID_ENABLE, IF_ID_FLUSH, ID_EX_ENABLE, ID_EX_FLUSH,
    output EX_MEM_FLUSH, MDU_START, MDU_TIMEOUT_ERR
  );
endinterface

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencer for the 5-stage RV32IM core: load-use stall, branch flush, MDU hold.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_stall_controller #(
  parameter int MDU_TIMEOUT = 64
`ifdef HAZARD_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input logic CLK,
  input logic RESET,
  hazard_stall_controller_if.slave bus
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] STALL_LOAD_CNT,
  output logic [CNT_W-1:0] STALL_MDU_CNT,
  output logic [CNT_W-1:0] FLUSH_BR_CNT
`endif
);

  localparam int WCW = (MDU_TIMEOUT > 1) ? $clog2(MDU_TIMEOUT) : 1;

  localparam logic [1:0] ST_RUN       = 2'd0;
  localparam logic [1:0] ST_MDU_WAIT  = 2'd1;
  localparam logic [1:0] ST_MDU_DRAIN = 2'd2;

  logic [1:0]     state;
  logic [1:0]     state_next;
  logic [WCW-1:0] wait_cnt;
  logic           timeout_err;

  logic load_use;
  logic pc_en;
  logic if_id_en;
  logic if_id_fl;
  logic id_ex_en;
  logic id_ex_fl;
  logic ex_mem_fl;
  logic mdu_start;
  logic timeout_hit;
  logic load_stall;
  logic branch_flush;

  // x0 is hardwired zero, so a load targeting it never creates a real dependency.
  always_comb begin
    load_use = bus.EX_IS_LOAD && (bus.EX_DEST_REG != 5'd0) &&
               ((bus.ID_USES_RS1 && (bus.ID_RS1 == bus.EX_DEST_REG)) ||
                (bus.ID_USES_RS2 && (bus.ID_RS2 == bus.EX_DEST_REG)));
  end

  always_comb begin
    state_next   = state;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_fl     = 1'b0;
    id_ex_en     = 1'b1;
    id_ex_fl     = 1'b0;
    ex_mem_fl    = 1'b0;
    mdu_start    = 1'b0;
    timeout_hit  = 1'b0;
    load_stall   = 1'b0;
    branch_flush = 1'b0;
    case (state)
      ST_RUN: begin
        if (bus.EX_IS_MDU) begin
          mdu_start  = 1'b1;
          pc_en      = 1'b0;
          if_id_en   = 1'b0;
          id_ex_en   = 1'b0;
          ex_mem_fl  = 1'b1;
          state_next = ST_MDU_WAIT;
        end else if (bus.EX_BRANCH_TAKEN) begin
          if_id_fl     = 1'b1;
          id_ex_fl     = 1'b1;
          branch_flush = 1'b1;
        end else if (load_use) begin
          pc_en      = 1'b0;
          if_id_en   = 1'b0;
          id_ex_fl   = 1'b1;
          load_stall = 1'b1;
        end
      end
      ST_MDU_WAIT: begin
        pc_en     = 1'b0;
        if_id_en  = 1'b0;
        id_ex_en  = 1'b0;
        ex_mem_fl = 1'b1;
        if (bus.MDU_DONE) begin
          state_next = ST_MDU_DRAIN;
        end else if (wait_cnt == WCW'(MDU_TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_next  = ST_MDU_DRAIN;
        end
      end
      ST_MDU_DRAIN: begin
        state_next = ST_RUN;
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
    end else begin
      state <= state_next;
      if (mdu_start) begin
        wait_cnt <= '0;
      end else if (state == ST_MDU_WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      timeout_err <= 1'b0;
    end else if (timeout_hit) begin
      timeout_err <= 1'b1;
    end
  end

  // Reset overrides the state-based controls so the pipeline free-runs while held in reset.
  always_comb begin
    bus.PC_ENABLE       = pc_en | RESET;
    bus.IF_ID_ENABLE    = if_id_en | RESET;
    bus.ID_EX_ENABLE    = id_ex_en | RESET;
    bus.IF_ID_FLUSH     = if_id_fl & ~RESET;
    bus.ID_EX_FLUSH     = id_ex_fl & ~RESET;
    bus.EX_MEM_FLUSH    = ex_mem_fl & ~RESET;
    bus.MDU_START       = mdu_start & ~RESET;
    bus.MDU_TIMEOUT_ERR = timeout_err;
  end

`ifdef HAZARD_PERF_CNT_EN
  // Saturating counters; RESET already forces state to RUN so no stall conditions leak in.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      STALL_LOAD_CNT <= '0;
      STALL_MDU_CNT  <= '0;
      FLUSH_BR_CNT   <= '0;
    end else begin
      if (load_stall && !(&STALL_LOAD_CNT)) begin
        STALL_LOAD_CNT <= STALL_LOAD_CNT + 1'b1;
      end
      if ((mdu_start || (state == ST_MDU_WAIT)) && !(&STALL_MDU_CNT)) begin
        STALL_MDU_CNT <= STALL_MDU_CNT + 1'b1;
      end
      if (branch_flush && !(&FLUSH_BR_CNT)) begin
        FLUSH_BR_CNT <= FLUSH_BR_CNT + 1'b1;
      end
    end
  end
`else
  // Performance counters are not built in this configuration.
`endif

endmodule
